// File: rtl/viterbi_pkg.sv
// ============================================================================
// viterbi_pkg : shared types, code constants and trellis helpers for the
//               K=3 rate-1/2 (7,5) hard-decision Viterbi decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package viterbi_pkg;

  localparam int N_STATES = 4;

  // Generator taps over {u, s1, s0}
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] state_t;

  function automatic logic [1:0] branch_out(state_t s, logic u);
    logic [2:0] r;
    r = {u, s};
    return {^(r & G0), ^(r & G1)};
  endfunction

  // Predecessor of next state {u, a} selected by its s0 bit
  function automatic state_t pred_state(state_t ns, logic sel);
    return {ns[0], sel};
  endfunction

  function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_dec_k3_acs.sv
// ============================================================================
// viterbi_acs : add-compare-select for one trellis state, saturating sums,
//               ties resolved toward the first (s0=0) predecessor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module viterbi_acs #(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_sel,
  output logic            dec
);

  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    sum0   = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    sum1   = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
    cand0  = (sum0 > PM_MAX) ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    cand1  = (sum1 > PM_MAX) ? {PM_W{1'b1}} : sum1[PM_W-1:0];
    dec    = (cand1 < cand0);
    pm_sel = dec ? cand1 : cand0;
  end

endmodule

`default_nettype wire

// File: rtl/viterbi_dec_k3.sv
// ============================================================================
// viterbi_dec_k3 : hard-decision register-exchange Viterbi decoder for the
//                  K=3 (7,5) code. Optional error counter: VITERBI_ERR_CNT_EN.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module viterbi_dec_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  coded,
  input  logic        coded_valid,
  output logic        info_out,
  output logic        info_valid
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  import viterbi_pkg::*;

  localparam int              CNT_W    = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [PM_W-1:0]     pm        [N_STATES];
  // The oldest survivor bit is only ever read from the next-state value,
  // so the stored survivors keep TB_DEPTH-1 bits.
  logic [TB_DEPTH-2:0] surv      [N_STATES];
  logic [TB_DEPTH-1:0] next_surv [N_STATES];
  logic [PM_W-1:0]     acs_pm    [N_STATES];
  logic [PM_W-1:0]     pm_norm   [N_STATES];
  logic                acs_dec   [N_STATES];
  logic [PM_W-1:0]     pm_min;
  state_t              best;
  logic [CNT_W-1:0]    sym_cnt;

  for (genvar g = 0; g < N_STATES; g++) begin : g_acs
    localparam state_t NS = state_t'(g);
    localparam state_t P0 = pred_state(NS, 1'b0);
    localparam state_t P1 = pred_state(NS, 1'b1);

    logic [1:0]          bm0;
    logic [1:0]          bm1;
    logic [TB_DEPTH-2:0] win;

    assign bm0 = hamming2(coded, branch_out(P0, NS[1]));
    assign bm1 = hamming2(coded, branch_out(P1, NS[1]));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_sel (acs_pm[g]),
      .dec    (acs_dec[g])
    );

    assign win          = acs_dec[g] ? surv[P1] : surv[P0];
    assign next_surv[g] = {win, NS[1]};
  end

  // Strict compare keeps the lowest-index state among equal minima
  always_comb begin
    pm_min = acs_pm[0];
    best   = state_t'(0);
    for (int i = 1; i < N_STATES; i++) begin
      if (acs_pm[i] < pm_min) begin
        pm_min = acs_pm[i];
        best   = state_t'(i);
      end
    end
    for (int i = 0; i < N_STATES; i++) begin
      pm_norm[i] = acs_pm[i] - pm_min;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STATES; i++) begin
        pm[i]   <= (i == 0) ? {PM_W{1'b0}} : {PM_W{1'b1}};
        surv[i] <= '0;
      end
      sym_cnt    <= '0;
      info_out   <= 1'b0;
      info_valid <= 1'b0;
    end else begin
      info_valid <= 1'b0;
      if (coded_valid) begin
        for (int i = 0; i < N_STATES; i++) begin
          pm[i]   <= pm_norm[i];
          surv[i] <= next_surv[i][TB_DEPTH-2:0];
        end
        if (sym_cnt != CNT_FULL) begin
          sym_cnt <= sym_cnt + 1'b1;
        end
        if (sym_cnt >= CNT_LAST) begin
          info_valid <= 1'b1;
          info_out   <= next_surv[best][TB_DEPTH-1];
        end
      end
    end
  end

`ifdef VITERBI_ERR_CNT_EN
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + 17'(pm_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (coded_valid && (sym_cnt >= CNT_TWO)) begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_viterbi_dec_k3.sv
// ============================================================================
// tb_viterbi_dec_k3 : randomized bench for viterbi_dec_k3 against an encoder
//                     plus delayed-info reference model.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_viterbi_dec_k3;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coded = 2'b00;
  logic       coded_valid = 1'b0;
  logic       info_out;
  logic       info_valid;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  viterbi_dec_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coded       (coded),
    .coded_valid (coded_valid),
    .info_out    (info_out),
    .info_valid  (info_valid)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder state {s1, s0} and the info bit behind the current symbol
  logic [1:0] enc_s = 2'b00;
  logic       cur_info = 1'b0;
  int         n_err_inj = 0;

  function automatic logic [1:0] enc_sym(logic [1:0] s, logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  // Model: a correctable stream decodes to the info bits, TB_DEPTH symbols late
  logic exp_valid = 1'b0;
  logic exp_out   = 1'b0;
  bit   hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_out   = 1'b0;
      hist.delete();
    end else if (coded_valid) begin
      hist.push_back(cur_info);
      if (hist.size() > TB_DEPTH) void'(hist.pop_front());
      if (hist.size() == TB_DEPTH) begin
        exp_valid = 1'b1;
        exp_out   = hist[0];
      end else begin
        exp_valid = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("info_valid", int'(info_valid), int'(exp_valid));
    check("info_out", int'(info_out), int'(exp_out));
`ifdef VITERBI_ERR_CNT_EN
    if (!rst_n) check("err_cnt_in_reset", int'(err_cnt), 0);
`endif
  end

  task automatic send(input logic u, input logic [1:0] flip);
    coded       = enc_sym(enc_s, u) ^ flip;
    coded_valid = 1'b1;
    cur_info    = u;
    @(posedge clk);
    #1;
    enc_s       = {u, enc_s[1]};
    coded_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    coded_valid = 1'b0;
    coded       = 2'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    enc_s       = 2'b00;
    n_err_inj   = 0;
    coded_valid = 1'b1;
    coded       = 2'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    coded_valid = 1'b0;
  endtask

  task automatic check_err(input string name, input int exp);
`ifdef VITERBI_ERR_CNT_EN
    check(name, int'(err_cnt), exp);
`endif
  endtask

  localparam int DIR_LEN = 8 + TB_DEPTH + 10;

  function automatic logic dir_bit(input int i);
    logic [7:0] head;
    head = 8'b1011_1110;  // bit i of the head = symbol i: 0,1,1,1,1,1,0,1
    return (i < 8) ? head[i] : 1'b0;
  endfunction

  task automatic directed(input int flip_idx, input int exp_err, input bit gaps);
    int lit[4] = '{0, 3, 1, 2};
    logic u;
    for (int i = 0; i < DIR_LEN; i++) begin
      u = dir_bit(i);
      if (i < 4) check("enc_literal", int'(enc_sym(enc_s, u)), lit[i]);
      if (gaps && ($urandom_range(3) == 0)) idle($urandom_range(1, 3));
      send(u, (i == flip_idx) ? 2'b01 : 2'b00);
      if (i == TB_DEPTH - 2) check("valid_before_warmup", int'(info_valid), 0);
      if (i == TB_DEPTH - 1) begin
        check("first_valid", int'(info_valid), 1);
        check("first_bit", int'(info_out), 0);
      end
    end
    idle(2);
    check_err("err_cnt_directed", exp_err);
  endtask

  initial begin
    // Reset held 3 cycles with symbols offered
    do_reset(3);
    check("reset_valid", int'(info_valid), 0);
    check("reset_out", int'(info_out), 0);
    check_err("reset_err_cnt", 0);

    // Error-free, then one flipped bit in symbol 6, then random gaps
    directed(-1, 0, 1'b0);
    do_reset(1);
    directed(6, 1, 1'b0);
    do_reset(1);
    directed(-1, 0, 1'b1);

    // Mid-stream single-cycle reset together with the encoder
    do_reset(1);
    for (int i = 0; i < 30; i++) send(1'($urandom), 2'b00);
    rst_n = 1'b0;
    enc_s = 2'b00;
    #1;
    check("valid_drops_on_reset", int'(info_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) send(1'($urandom), 2'b00);
    for (int i = 0; i < TB_DEPTH + 2; i++) send(1'b0, 2'b00);

    // Long random stream, errors at least 15 symbols apart
    do_reset(1);
    begin
      int last_err;
      logic [1:0] flip;
      last_err = -100;
      for (int i = 0; i < 10000; i++) begin
        flip = 2'b00;
        if (i >= 2 && (i - last_err) >= 15 && $urandom_range(9) == 0) begin
          flip = $urandom_range(1) ? 2'b10 : 2'b01;
          last_err = i;
          n_err_inj++;
        end
        if ($urandom_range(15) == 0) idle(1);
        send(1'($urandom), flip);
      end
      for (int i = 0; i < TB_DEPTH + 10; i++) send(1'b0, 2'b00);
      idle(2);
      check_err("err_cnt_random", n_err_inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/viterbi_dec_k3.md
# viterbi_dec_k3

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators 7/5 octal) produced by the lab8 encoder. Sits directly downstream of the encoder: it consumes one 2-bit `coded` symbol per accepted cycle and recovers the original `info` bit stream after a fixed traceback delay. Survivor paths use register exchange, so the block contains no RAM.

## Interface
Parameters:
- `TB_DEPTH`, default 16: survivor length in symbols. Equals the decode latency. Legal range 4..64.
- `PM_W`, default 4: path-metric width in bits. Must be at least 3.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `coded`, input, 2: received symbol. `coded[1]` = u^s1^s0 (G0=111). `coded[0]` = u^s0 (G1=101).
- `coded_valid`, input, 1: `coded` is accepted on any edge where this is 1.
- `info_out`, output, 1: decoded bit.
- `info_valid`, output, 1: `info_out` is valid this cycle.
- `err_cnt`, output, 16: detected channel-error count. Present only with `VITERBI_ERR_CNT_EN`.

## Operation
- Encoder state is s = {s1, s0}, with s1 the most recent bit. Input u moves the encoder to {u, s1}.
- Predecessors of state {u, a} are {a, 0} and {a, 1}.
- Branch metric = Hamming distance (0..2) between `coded` and the expected branch label.
- ACS per state:
  - cand = pm[pred] + bm, saturating at 2^PM_W−1.
  - Choose the smaller candidate. On a tie, choose the predecessor with s0=0.
- Normalization: subtract min(new metrics) from all four new metrics every accepted cycle, so the best state always has metric 0.
- Survivor update: surv[ns] = {surv[pred][TB_DEPTH-2:0], ns[1]}.
- Best state: lowest index whose normalized metric is 0.
- Reset values:
  - pm = {0, max, max, max} for states 0..3.
  - All survivors = 0.
  - `info_out` = 0, `info_valid` = 0, `err_cnt` = 0.
  - Symbol counter = 0.
- Symbol counter increments on each accepted symbol and saturates at TB_DEPTH.
- Cycles with `coded_valid` = 0:
  - No state changes.
  - `info_valid` = 0.
  - `info_out` holds its last value.

## Timing
- Symbol k (0-based from reset) is accepted on edge E_k.
- Decoded bit k = next_surv[best_next][TB_DEPTH-1], registered on edge E_(k+TB_DEPTH-1). It is visible with `info_valid` = 1 for the following cycle.
- Latency: TB_DEPTH accepted symbols. With continuous valid this is TB_DEPTH−1 clocks from acceptance to register.
- `info_valid` = 1 only in cycles after an accepting edge on which the counter had reached TB_DEPTH−1 or more. It is never asserted during the first TB_DEPTH−1 symbols.
- Back-to-back symbols give one decoded bit per clock. There is no backpressure.
- Reset asserted mid-stream clears everything immediately, including `info_valid`. Decoding restarts from state 0 at the first symbol after release; the encoder must be reset at the same time.
- Metric saturation only occurs from the initial "max" values and disappears after two symbols. No wrap-around is possible.

## Configuration
- `VITERBI_ERR_CNT_EN` defined:
  - `err_cnt` port exists.
  - It increments by the pre-normalization minimum metric (0, 1 or 2) on each accepted symbol once the counter is ≥ 2.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset.
- `VITERBI_ERR_CNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `viterbi_pkg`:
  - `N_STATES` = 4.
  - Generator constants `G0` = 3'b111, `G1` = 3'b101.
  - typedef `state_t` (2-bit).
  - Function `branch_out(state_t s, logic u)` returning the 2-bit label.
  - Predecessor function.
- Sub-module `viterbi_acs`, instantiated 4 times in a generate loop.
  - Inputs: two candidate metrics, two branch metrics.
  - Outputs: selected metric, decision bit.
- Top level holds:
  - Metric and survivor registers.
  - Normalization and best-state selection.
  - Counter and output registers.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles → `info_valid` = 0, `info_out` = 0, `err_cnt` = 0, with no change even while `coded_valid` = 1.
- Error-free stream from the lab8 encoder, `coded_valid` = 1 continuously: info = 0, then 1×5, 0, 1, then 0×(TB_DEPTH+10) → `info_out` reproduces the same sequence. The first `info_valid` appears in the cycle after symbol TB_DEPTH−1 is accepted. `err_cnt` stays 0.
- Single flipped bit in symbol 6 of the same stream → output bit-exact with the error-free case, and `err_cnt` = 1.
- Insert random `coded_valid` = 0 gaps into the error-free stream → identical decoded sequence. `info_valid` is high exactly once per accepted symbol after warm-up.
- Pulse `rst_n` low for 1 cycle mid-stream, resetting the encoder at the same time → `info_valid` drops immediately, returns after TB_DEPTH new symbols, and the decoded data matches the post-reset input.
- Random info (10k bits) with errors spaced at least 15 symbols apart → zero decoded-bit mismatches against the reference model. `err_cnt` equals the number of injected errors.
